// File: rtl/aes_bus_driver.sv
// Bus initiator for the aes register block: loads key/config, runs init/next,
// polls STATUS and returns the 128-bit result with a done pulse.
module aes_bus_driver #(
  parameter int POLL_GAP   = 4,
  parameter int POLL_LIMIT = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         encdec,
  input  logic         keylen,
  input  logic         key_reload,
  input  logic [255:0] key,
  input  logic [127:0] block,
  output logic         ready,
  output logic         done,
  output logic         error,
  output logic [127:0] result,
  output logic         cs,
  output logic         we,
  output logic [7:0]   address,
  output logic [31:0]  write_data,
  input  logic [31:0]  read_data
);

  localparam int GCW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam int PCW = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT) : 1;

  localparam logic [7:0] ADDR_CTRL   = 8'h08;
  localparam logic [7:0] ADDR_STATUS = 8'h09;
  localparam logic [7:0] ADDR_CONFIG = 8'h0A;
  localparam logic [7:0] ADDR_KEY    = 8'h10;
  localparam logic [7:0] ADDR_BLOCK  = 8'h20;
  localparam logic [7:0] ADDR_RESULT = 8'h30;

  typedef enum logic [3:0] {
    S_IDLE, S_WR_KEY, S_WR_CFG, S_WR_INIT, S_GAP, S_POLL_RDY,
    S_WR_BLK, S_WR_NEXT, S_POLL_VLD, S_RD_RES, S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [2:0]       idx, idx_nxt;
  logic [GCW-1:0]   gap_cnt, gap_nxt;
  logic [PCW-1:0]   poll_cnt, poll_nxt;
  logic             gap_vld, gap_vld_nxt;
  logic             encdec_r, keylen_r, reload_r;
  logic [255:0]     key_r;
  logic [127:0]     block_r;
  logic [31:0]      shadow [4];
  logic             key_loaded, loaded_keylen;
  logic             accept, load_key, timeout, capture, finish;
  logic             reload_req;
  logic [2:0]       last_idx;
  logic             encdec_nxt, keylen_nxt;
  logic [255:0]     key_nxt;
  logic [127:0]     block_nxt;
  logic             cs_nxt, we_nxt;
  logic [7:0]       address_nxt;
  logic [31:0]      write_data_nxt;

  function automatic logic [31:0] key_word(input logic [255:0] k, input logic [2:0] i);
    logic [255:0] t;
    t = k << {i, 5'b00000};
    return t[255:224];
  endfunction

  function automatic logic [31:0] block_word(input logic [127:0] b, input logic [1:0] i);
    logic [127:0] t;
    t = b << {i, 5'b00000};
    return t[127:96];
  endfunction

  assign reload_req = key_reload || !key_loaded || (keylen != loaded_keylen);
  assign last_idx   = keylen_r ? 3'd7 : 3'd3;
  assign encdec_nxt = accept ? encdec : encdec_r;
  assign keylen_nxt = accept ? keylen : keylen_r;
  assign key_nxt    = accept ? key : key_r;
  assign block_nxt  = accept ? block : block_r;

  // Next-state, index/counter updates and per-state strobes.
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    gap_nxt     = gap_cnt;
    poll_nxt    = poll_cnt;
    gap_vld_nxt = gap_vld;
    accept      = 1'b0;
    load_key    = 1'b0;
    timeout     = 1'b0;
    capture     = 1'b0;
    finish      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          idx_nxt   = 3'd0;
          state_nxt = reload_req ? S_WR_KEY : S_WR_CFG;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_WR_KEY: begin
        if (idx == last_idx) begin
          state_nxt = S_WR_CFG;
          idx_nxt   = 3'd0;
        end else begin
          idx_nxt = idx + 3'd1;
        end
      end
      S_WR_CFG: begin
        state_nxt = reload_r ? S_WR_INIT : S_WR_BLK;
      end
      S_WR_INIT: begin
        state_nxt   = S_GAP;
        gap_nxt     = '0;
        gap_vld_nxt = 1'b0;
      end
      S_GAP: begin
        if (gap_cnt == GCW'(POLL_GAP - 1)) begin
          state_nxt = gap_vld ? S_POLL_VLD : S_POLL_RDY;
          poll_nxt  = '0;
        end else begin
          gap_nxt = gap_cnt + GCW'(1);
        end
      end
      S_POLL_RDY: begin
        if (read_data[0]) begin
          load_key  = 1'b1;
          state_nxt = S_WR_BLK;
          idx_nxt   = 3'd0;
        end else if (poll_cnt == PCW'(POLL_LIMIT - 1)) begin
          timeout   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          poll_nxt = poll_cnt + PCW'(1);
        end
      end
      S_WR_BLK: begin
        if (idx == 3'd3) begin
          state_nxt = S_WR_NEXT;
          idx_nxt   = 3'd0;
        end else begin
          idx_nxt = idx + 3'd1;
        end
      end
      S_WR_NEXT: begin
        state_nxt   = S_GAP;
        gap_nxt     = '0;
        gap_vld_nxt = 1'b1;
      end
      S_POLL_VLD: begin
        if (read_data[1:0] == 2'b11) begin
          state_nxt = S_RD_RES;
          idx_nxt   = 3'd0;
        end else if (poll_cnt == PCW'(POLL_LIMIT - 1)) begin
          timeout   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          poll_nxt = poll_cnt + PCW'(1);
        end
      end
      S_RD_RES: begin
        capture = 1'b1;
        if (idx == 3'd3) begin
          state_nxt = S_DONE;
          idx_nxt   = 3'd0;
        end else begin
          idx_nxt = idx + 3'd1;
        end
      end
      S_DONE: begin
        finish    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bus signals are decoded from the next state so they register alongside it.
  always_comb begin
    cs_nxt         = 1'b0;
    we_nxt         = 1'b0;
    address_nxt    = 8'h00;
    write_data_nxt = 32'h0000_0000;
    case (state_nxt)
      S_WR_KEY: begin
        cs_nxt = 1'b1; we_nxt = 1'b1;
        address_nxt    = ADDR_KEY + {5'b00000, idx_nxt};
        write_data_nxt = key_word(key_nxt, idx_nxt);
      end
      S_WR_CFG: begin
        cs_nxt = 1'b1; we_nxt = 1'b1;
        address_nxt    = ADDR_CONFIG;
        write_data_nxt = {30'd0, keylen_nxt, encdec_nxt};
      end
      S_WR_INIT: begin
        cs_nxt = 1'b1; we_nxt = 1'b1;
        address_nxt    = ADDR_CTRL;
        write_data_nxt = 32'h0000_0001;
      end
      S_POLL_RDY, S_POLL_VLD: begin
        cs_nxt      = 1'b1;
        address_nxt = ADDR_STATUS;
      end
      S_WR_BLK: begin
        cs_nxt = 1'b1; we_nxt = 1'b1;
        address_nxt    = ADDR_BLOCK + {6'd0, idx_nxt[1:0]};
        write_data_nxt = block_word(block_nxt, idx_nxt[1:0]);
      end
      S_WR_NEXT: begin
        cs_nxt = 1'b1; we_nxt = 1'b1;
        address_nxt    = ADDR_CTRL;
        write_data_nxt = 32'h0000_0002;
      end
      S_RD_RES: begin
        cs_nxt      = 1'b1;
        address_nxt = ADDR_RESULT + {6'd0, idx_nxt[1:0]};
      end
      default: cs_nxt = 1'b0;
    endcase
  end

  // State, operand latches, key bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      idx           <= 3'd0;
      gap_cnt       <= '0;
      poll_cnt      <= '0;
      gap_vld       <= 1'b0;
      encdec_r      <= 1'b0;
      keylen_r      <= 1'b0;
      reload_r      <= 1'b0;
      key_r         <= 256'd0;
      block_r       <= 128'd0;
      for (int i = 0; i < 4; i++) shadow[i] <= 32'd0;
      key_loaded    <= 1'b0;
      loaded_keylen <= 1'b0;
      ready         <= 1'b1;
      done          <= 1'b0;
      error         <= 1'b0;
      result        <= 128'd0;
      cs            <= 1'b0;
      we            <= 1'b0;
      address       <= 8'h00;
      write_data    <= 32'd0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      gap_cnt  <= gap_nxt;
      poll_cnt <= poll_nxt;
      gap_vld  <= gap_vld_nxt;
      if (accept) begin
        encdec_r <= encdec;
        keylen_r <= keylen;
        reload_r <= reload_req;
        key_r    <= key;
        block_r  <= block;
      end
      if (load_key) begin
        key_loaded    <= 1'b1;
        loaded_keylen <= keylen_r;
      end else if (timeout) begin
        key_loaded <= 1'b0;
      end
      if (capture) shadow[idx[1:0]] <= read_data;
      if (finish) result <= {shadow[0], shadow[1], shadow[2], shadow[3]};
      done       <= finish;
      error      <= timeout;
      ready      <= (state_nxt == S_IDLE);
      cs         <= cs_nxt;
      we         <= we_nxt;
      address    <= address_nxt;
      write_data <= write_data_nxt;
    end
  end

endmodule
